// File: rtl/i_buf_ds_filter.sv
// Differential input receiver with per-channel synchroniser, deglitch filter and keeper.
// Optional loss-of-signal detection is built when I_BUF_DS_FILTER_LOS_EN is defined.
module i_buf_ds_filter #(
    parameter int unsigned WIDTH        = 4,
    parameter string       WEAK_KEEPER  = "NONE",
    parameter int unsigned FILTER_DEPTH = 3,
    parameter int unsigned LOS_CYCLES   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I_P,
    input  logic [WIDTH-1:0] I_N,
    input  logic [WIDTH-1:0] EN,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] EDGE,
    output logic [WIDTH-1:0] LOS
);

    localparam bit               KEEP_UP    = (WEAK_KEEPER == "PULLUP");
    localparam bit               KEEP_DN    = (WEAK_KEEPER == "PULLDOWN");
    localparam bit               KEEP_DRIVE = KEEP_UP || KEEP_DN;
    localparam logic [WIDTH-1:0] RST_VAL    = KEEP_UP ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [3:0]       CNT_LAST   = 4'(FILTER_DEPTH - 1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH=%0d illegal: legal values are 1..32", WIDTH);
    end
    if (FILTER_DEPTH < 1 || FILTER_DEPTH > 15) begin : g_bad_depth
        $error("FILTER_DEPTH=%0d illegal: legal values are 1..15", FILTER_DEPTH);
    end
    if (LOS_CYCLES < 2 || LOS_CYCLES > 255) begin : g_bad_los
        $error("LOS_CYCLES=%0d illegal: legal values are 2..255", LOS_CYCLES);
    end
    if (!(WEAK_KEEPER == "NONE" || KEEP_UP || KEEP_DN)) begin : g_bad_keeper
        $error("WEAK_KEEPER illegal: legal values are \"NONE\", \"PULLUP\", \"PULLDOWN\"");
    end

    logic             r_run;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_raw_s1, r_raw_s2;
    logic [WIDTH-1:0] r_en_s1, r_en_s2;
    logic [WIDTH-1:0] r_o, r_edge;
    logic [3:0]       r_flt_cnt [WIDTH];
    logic [WIDTH-1:0] w_raw;

    // Invalid (P==N) samples and keeper-less disables fall back to the last resolved value.
    always_comb begin
        w_raw = r_hold;
        for (int i = 0; i < WIDTH; i++) begin
            if (EN[i]) begin
                if (I_P[i] != I_N[i]) w_raw[i] = I_P[i];
            end else if (KEEP_DRIVE) begin
                w_raw[i] = KEEP_UP;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_run <= 1'b0;
        else      r_run <= 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hold   <= RST_VAL;
            r_raw_s1 <= RST_VAL;
            r_raw_s2 <= RST_VAL;
            r_en_s1  <= '0;
            r_en_s2  <= '0;
        end else if (r_run) begin
            r_hold   <= w_raw;
            r_raw_s1 <= w_raw;
            r_raw_s2 <= r_raw_s1;
            r_en_s1  <= EN;
            r_en_s2  <= r_en_s1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_o    <= RST_VAL;
            r_edge <= '0;
            for (int i = 0; i < WIDTH; i++) r_flt_cnt[i] <= '0;
        end else if (r_run) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_edge[i] <= 1'b0;
                if (!r_en_s2[i]) begin
                    r_flt_cnt[i] <= '0;
                    if (KEEP_DRIVE && (r_o[i] != KEEP_UP)) begin
                        r_o[i]    <= KEEP_UP;
                        r_edge[i] <= 1'b1;
                    end
                end else if (r_raw_s2[i] != r_o[i]) begin
                    if (r_flt_cnt[i] == CNT_LAST) begin
                        r_o[i]       <= ~r_o[i];
                        r_edge[i]    <= 1'b1;
                        r_flt_cnt[i] <= '0;
                    end else begin
                        r_flt_cnt[i] <= r_flt_cnt[i] + 4'd1;
                    end
                end else begin
                    r_flt_cnt[i] <= '0;
                end
            end
        end
    end

    assign O    = r_o;
    assign EDGE = r_edge;

`ifdef I_BUF_DS_FILTER_LOS_EN
    localparam logic [7:0] LOS_MAX = 8'(LOS_CYCLES);

    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] r_inv_s1, r_inv_s2;
    logic [7:0]       r_los_cnt [WIDTH];
    logic [WIDTH-1:0] w_los;

    assign w_inv = EN & ~(I_P ^ I_N);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_inv_s1 <= '0;
            r_inv_s2 <= '0;
            for (int i = 0; i < WIDTH; i++) r_los_cnt[i] <= '0;
        end else if (r_run) begin
            r_inv_s1 <= w_inv;
            r_inv_s2 <= r_inv_s1;
            for (int i = 0; i < WIDTH; i++) begin
                if (!r_en_s2[i] || !r_inv_s2[i]) r_los_cnt[i] <= '0;
                else if (r_los_cnt[i] != LOS_MAX) r_los_cnt[i] <= r_los_cnt[i] + 8'd1;
            end
        end
    end

    always_comb begin
        w_los = '0;
        for (int i = 0; i < WIDTH; i++) w_los[i] = (r_los_cnt[i] == LOS_MAX);
    end

    assign LOS = w_los;
`else
    assign LOS = '0;
`endif

endmodule
